traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 203 ++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Watches the four lamp groups of a main/side road junction and checks that the
// controller only shows legal phases, steps through them in order, and keeps
// each phase within its dwell window. The first detected fault is latched with
// its cause until software clears it. Also reports the decoded phase and counts
// completed light cycles.
module traffic_light_monitor #(
  parameter int unsigned MIN_DWELL = 3,
  parameter int unsigned MAX_DWELL = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  light_M1,
  input  logic [2:0]  light_M2,
  input  logic [2:0]  light_MT,
  input  logic [2:0]  light_S,
  input  logic        clr_fault,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic [2:0]  phase,
  output logic        phase_valid,
  output logic [15:0] cycle_count
);

  // Lamp encodings (bit2=red, bit1=yellow, bit0=green).
  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  // Phase identifiers; 7 means the lamps match no legal phase.
  localparam logic [2:0] PH_LAST    = 3'd5;
  localparam logic [2:0] PH_UNKNOWN = 3'd7;

  // Fault causes, listed from highest to lowest priority.
  localparam logic [2:0] CODE_NONE     = 3'd0;
  localparam logic [2:0] CODE_ENCODING = 3'd1;
  localparam logic [2:0] CODE_COMBO    = 3'd2;
  localparam logic [2:0] CODE_SEQUENCE = 3'd3;
  localparam logic [2:0] CODE_SHORT    = 3'd4;
  localparam logic [2:0] CODE_STUCK    = 3'd5;

  // Dwell limits widened by one bit so MAX_DWELL+1 never wraps against a
  // saturated 16-bit counter.
  localparam logic [16:0] MIN_LIMIT   = 17'(MIN_DWELL);
  localparam logic [16:0] STUCK_LIMIT = 17'(MAX_DWELL) + 17'd1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] dwell_q, dwell_d;
  logic        exempt_q, exempt_d;     // current phase is the first one after SYNC
  logic        fault_d;
  logic [2:0]  code_d;
  logic [2:0]  phase_d;
  logic        valid_d;
  logic [15:0] count_d;

  logic        enc_err;
  logic        combo_err;
  logic [2:0]  cur_phase;
  logic [2:0]  succ_phase;
  logic        phase_change;
  logic [15:0] dwell_inc;
  logic [2:0]  det_code;

  function automatic logic is_one_hot(input logic [2:0] v);
    return (v == LAMP_G) || (v == LAMP_Y) || (v == LAMP_R);
  endfunction

  // Decode the sampled lamps into a legal phase number or an error class.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    cur_phase = PH_UNKNOWN;
    enc_err   = !(is_one_hot(light_M1) && is_one_hot(light_M2) &&
                  is_one_hot(light_MT) && is_one_hot(light_S));
    case ({light_M1, light_M2, light_MT, light_S})
      {LAMP_G, LAMP_G, LAMP_R, LAMP_R}: cur_phase = 3'd0;
      {LAMP_G, LAMP_Y, LAMP_R, LAMP_R}: cur_phase = 3'd1;
      {LAMP_G, LAMP_R, LAMP_G, LAMP_R}: cur_phase = 3'd2;
      {LAMP_Y, LAMP_R, LAMP_Y, LAMP_R}: cur_phase = 3'd3;
      {LAMP_R, LAMP_R, LAMP_R, LAMP_G}: cur_phase = 3'd4;
      {LAMP_R, LAMP_R, LAMP_R, LAMP_Y}: cur_phase = 3'd5;
      default:                          cur_phase = PH_UNKNOWN;
    endcase
    combo_err = !enc_err && (cur_phase == PH_UNKNOWN);
  end

  // Helpers relative to the phase currently being tracked.
  always_comb begin
    succ_phase   = (phase == PH_LAST) ? 3'd0 : phase + 3'd1;
    phase_change = (cur_phase != phase);
    dwell_inc    = (dwell_q == 16'hFFFF) ? dwell_q : dwell_q + 16'd1;
  end

  // Next-state, fault detection and next output values.
  always_comb begin
    state_d  = state_q;
    dwell_d  = dwell_q;
    exempt_d = exempt_q;
    fault_d  = fault;
    code_d   = fault_code;
    phase_d  = cur_phase;
    count_d  = cycle_count;
    det_code = CODE_NONE;

    case (state_q)
      ST_SYNC: begin
        // Only lamp-level errors are meaningful before a phase is locked.
        if (enc_err)        det_code = CODE_ENCODING;
        else if (combo_err) det_code = CODE_COMBO;

        if (det_code != CODE_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = det_code;
          dwell_d = 16'd0;
        end else begin
          state_d  = ST_TRACK;
          dwell_d  = 16'd1;
          exempt_d = 1'b1;
        end
      end

      ST_TRACK: begin
        if (enc_err)        det_code = CODE_ENCODING;
        else if (combo_err) det_code = CODE_COMBO;
        else if (phase_change) begin
          if (cur_phase != succ_phase)
            det_code = CODE_SEQUENCE;
          else if (!exempt_q && ({1'b0, dwell_q} < MIN_LIMIT))
            det_code = CODE_SHORT;
        end else if ({1'b0, dwell_inc} >= STUCK_LIMIT) begin
          det_code = CODE_STUCK;
        end

        if (det_code != CODE_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = det_code;
          dwell_d = dwell_inc;
        end else if (phase_change) begin
          dwell_d  = 16'd1;
          exempt_d = 1'b0;
          if ((phase == PH_LAST) && (cycle_count != 16'hFFFF))
            count_d = cycle_count + 16'd1;
        end else begin
          dwell_d = dwell_inc;
        end
      end

      ST_FAULT: begin
        // Faults are frozen here; only a clear leaves, and it wins over
        // anything the lamps show this cycle.
        if (clr_fault) begin
          state_d = ST_SYNC;
          fault_d = 1'b0;
          code_d  = CODE_NONE;
          dwell_d = 16'd0;
        end
      end

      default: begin
        state_d = ST_SYNC;
        fault_d = 1'b0;
        code_d  = CODE_NONE;
        dwell_d = 16'd0;
      end
    endcase

    valid_d = (state_d == ST_TRACK);
  end

  // State and output registers; reset discards all tracking immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    if (rst) begin
      state_q     <= ST_SYNC;
      dwell_q     <= 16'd0;
      exempt_q    <= 1'b1;
      fault       <= 1'b0;
      fault_code  <= CODE_NONE;
      phase       <= PH_UNKNOWN;
      phase_valid <= 1'b0;
      cycle_count <= 16'd0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      exempt_q    <= exempt_d;
      fault       <= fault_d;
      fault_code  <= code_d;
      phase       <= phase_d;
      phase_valid <= valid_d;
      cycle_count <= count_d;
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed lamp sequences, a behavioural model
// that checks every output on every clock, and literal spot checks.
module tb_traffic_light_monitor;

  localparam int MIN_D = 3;
  localparam int MAX_D = 60;

  localparam logic [2:0] G = 3'b001;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] R = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  light_M1, light_M2, light_MT, light_S;
  logic        clr_fault;
  logic        fault;
  logic [2:0]  fault_code;
  logic [2:0]  phase;
  logic        phase_valid;
  logic [15:0] cycle_count;

  int n_cmp  = 0;
  int n_fail = 0;

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D)) dut (
    .clk         (clk),
    .rst         (rst),
    .light_M1    (light_M1),
    .light_M2    (light_M2),
    .light_MT    (light_MT),
    .light_S     (light_S),
    .clr_fault   (clr_fault),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .phase_valid (phase_valid),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Lamp pattern of each legal phase, order M1,M2,MT,S.
  function automatic logic [11:0] lamps_of(input int p);
    case (p)
      0:       return {G, G, R, R};
      1:       return {G, Y, R, R};
      2:       return {G, R, G, R};
      3:       return {Y, R, Y, R};
      4:       return {R, R, R, G};
      default: return {R, R, R, Y};
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  localparam int M_SYNC  = 0;
  localparam int M_TRACK = 1;
  localparam int M_FAULT = 2;

  int m_mode, m_phase, m_dwell, m_cycles, m_code;
  bit m_fault, m_exempt;

  task automatic model_reset();
    m_mode = M_SYNC; m_phase = 7; m_dwell = 0; m_cycles = 0;
    m_code = 0; m_fault = 0; m_exempt = 1;
  endtask

  task automatic model_step(input logic [11:0] l, input bit clr);
    bit enc;
    int idx;
    int c;
    enc = 0;
    for (int k = 0; k < 4; k++)
      if ($countones(l[k*3 +: 3]) != 1) enc = 1;
    idx = 7;
    for (int p = 0; p < 6; p++)
      if (l == lamps_of(p)) idx = p;
    c = 0;
    if (m_mode == M_FAULT) begin
      if (clr) begin m_mode = M_SYNC; m_fault = 0; m_code = 0; end
    end else begin
      if (enc) c = 1;
      else if (idx == 7) c = 2;
      else if (m_mode == M_TRACK) begin
        if (idx != m_phase) begin
          if (idx != (m_phase + 1) % 6) c = 3;
          else if (!m_exempt && m_dwell < MIN_D) c = 4;
        end else if (m_dwell + 1 > MAX_D) c = 5;
      end
      if (c != 0) begin
        m_mode = M_FAULT; m_fault = 1; m_code = c;
      end else if (m_mode == M_SYNC) begin
        m_mode = M_TRACK; m_dwell = 1; m_exempt = 1;
      end else if (idx != m_phase) begin
        if (m_phase == 5 && m_cycles < 65535) m_cycles++;
        m_dwell = 1; m_exempt = 0;
      end else begin
        m_dwell++;
      end
    end
    m_phase = idx;
  endtask

  // Compare process: advance the model on each edge, check just after it.
  always @(posedge clk) begin : compare
    logic [11:0] smp;
    bit          smp_clr;
    smp     = {light_M1, light_M2, light_MT, light_S};
    smp_clr = clr_fault;
    if (rst) model_reset();
    else     model_step(smp, smp_clr);
    #1;
    check("fault",       fault,       m_fault);
    check("fault_code",  fault_code,  m_code);
    check("phase",       phase,       m_phase);
    check("phase_valid", phase_valid, (m_mode == M_TRACK));
    check("cycle_count", cycle_count, m_cycles);
  end

  // ---------------- stimulus ----------------
  task automatic drive_raw(input logic [11:0] l, input logic clr, input int n);
    repeat (n) begin
      {light_M1, light_M2, light_MT, light_S} = l;
      clr_fault = clr;
      @(negedge clk);
    end
    clr_fault = 1'b0;
  endtask

  task automatic drive_phase(input int p, input int n);
    drive_raw(lamps_of(p), 1'b0, n);
  endtask

  initial begin
    rst = 1'b1;
    clr_fault = 1'b0;
    {light_M1, light_M2, light_MT, light_S} = lamps_of(0);
    repeat (2) @(negedge clk);
    check("rst_fault", fault, 0);
    check("rst_phase", phase, 7);
    check("rst_valid", phase_valid, 0);
    rst = 1'b0;

    // Two clean cycles, with a stray clear in TRACK, then back into P0.
    drive_phase(0, 1);
    check("first_valid", phase_valid, 1);
    check("first_phase", phase, 0);
    drive_phase(0, 4);
    for (int pass = 0; pass < 2; pass++)
      for (int p = (pass == 0) ? 1 : 0; p < 6; p++) begin
        if (p == 1) begin
          drive_phase(1, 2);
          drive_raw(lamps_of(1), 1'b1, 1);
          drive_phase(1, 2);
        end else drive_phase(p, 5);
      end
    drive_phase(0, 1);
    check("two_cycles", cycle_count, 2);
    check("clean_fault", fault, 0);

    // Encoding error in P2, later errors must not overwrite the code.
    drive_phase(0, 4);
    drive_phase(1, 5);
    drive_phase(2, 2);
    drive_raw({G, R, G, 3'b011}, 1'b0, 1);
    check("enc_fault", fault, 1);
    check("enc_code", fault_code, 1);
    drive_phase(0, 2);
    drive_raw({R, R, R, R}, 1'b0, 1);
    check("frozen_code", fault_code, 1);
    check("fault_phase7", phase, 7);

    // Clear, then a skipped phase.
    drive_raw(lamps_of(0), 1'b1, 1);
    check("clr_fault0", fault, 0);
    check("clr_code0", fault_code, 0);
    drive_phase(0, 4);
    drive_phase(2, 1);
    check("seq_code", fault_code, 3);

    // Short dwell on P1 (first phase after SYNC is P0, so P1 is checked).
    drive_raw(lamps_of(2), 1'b1, 1);
    drive_phase(0, 3);
    drive_phase(1, 2);
    drive_phase(2, 1);
    check("short_code", fault_code, 4);

    // Clear against an illegal combination; first phase after SYNC exempt.
    drive_raw({R, R, R, R}, 1'b1, 1);
    check("clr_wins", fault, 0);
    check("clr_wins_code", fault_code, 0);
    drive_phase(1, 1);
    check("resync_valid", phase_valid, 1);
    drive_phase(2, 4);
    check("exempt_ok", fault, 0);

    // Stuck phase: 60 cycles legal, the 61st raises the fault.
    drive_phase(3, 3);
    drive_phase(4, 60);
    check("dwell60_ok", fault, 0);
    drive_phase(4, 1);
    check("stuck_code", fault_code, 5);

    // Clear alongside an encoding error, then a bad combination from SYNC.
    drive_raw(12'h000, 1'b1, 1);
    check("clr_enc", fault, 0);
    drive_raw({R, R, R, R}, 1'b0, 1);
    check("sync_combo", fault_code, 2);

    // Build cycle_count to 4, then reset asynchronously in the middle of P3.
    drive_raw(lamps_of(0), 1'b1, 1);
    for (int pass = 0; pass < 2; pass++)
      for (int p = 0; p < 6; p++) drive_phase(p, 5);
    for (int p = 0; p < 3; p++) drive_phase(p, 5);
    drive_phase(3, 2);
    check("count4", cycle_count, 4);
    #3 rst = 1'b1;
    #1;
    check("arst_fault", fault, 0);
    check("arst_code", fault_code, 0);
    check("arst_phase", phase, 7);
    check("arst_valid", phase_valid, 0);
    check("arst_count", cycle_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive_phase(3, 1);
    drive_phase(4, 3);
    check("post_rst_exempt", fault, 0);
    check("post_rst_valid", phase_valid, 1);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
